// File: rtl/fg_dac_spi_out.sv
// fg_dac_spi_out
//   Output stage of the function generator. Each accepted sample is summed
//   with a DC offset, clamped to the unsigned waveform range, truncated to the
//   DAC resolution and shifted out to an SPI DAC (mode 0, MSB first) behind a
//   4-bit command header. A one-deep pending slot holds a sample that arrives
//   while a frame is in flight; overwriting a full slot raises overrun_o.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_i          synchronous reset, active-high
//   enable_i       when low no new frame starts, pending is dropped
//   sample_valid_i sample strobe
//   wave_i         signed waveform sample (WAVEFORM_BITWIDTH+1 bits)
//   offset_i       signed DC offset (WAVEFORM_BITWIDTH+1 bits)
//   clr_overrun_i  clears overrun_o (wins over a same-cycle set)
//   spi_sclk_o     SPI clock, idle low
//   spi_mosi_o     SPI data
//   spi_cs_o       SPI chip select, active-low
//   busy_o         frame in progress (LOAD/SHIFT/CSHOLD)
//   overrun_o      sticky pending-overwrite flag
module fg_dac_spi_out #(
  parameter int         WAVEFORM_BITWIDTH = 16,
  parameter int         DAC_BITWIDTH      = 12,
  parameter logic [3:0] CMD               = 4'b0011,
  parameter int         SCLK_DIV          = 2,
  parameter int         CS_HIGH_CYCLES    = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         enable_i,
  input  logic                         sample_valid_i,
  input  logic [WAVEFORM_BITWIDTH:0]   wave_i,
  input  logic [WAVEFORM_BITWIDTH:0]   offset_i,
  input  logic                         clr_overrun_i,
  output logic                         spi_sclk_o,
  output logic                         spi_mosi_o,
  output logic                         spi_cs_o,
  output logic                         busy_o,
  output logic                         overrun_o
);

  localparam int W          = WAVEFORM_BITWIDTH;
  localparam int FRAME_BITS = DAC_BITWIDTH + 4;
  localparam int PH_W       = $clog2(2 * SCLK_DIV);
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int HOLD_W     = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_CSHOLD} state_t;

  state_t                  state, state_nxt;
  logic [W+1:0]            sum;
  logic [W-1:0]            clamp;
  logic [DAC_BITWIDTH-1:0] code;
  logic [DAC_BITWIDTH-1:0] pend_code;
  logic                    pend_vld;
  logic [FRAME_BITS-1:0]   shreg;
  logic [PH_W-1:0]         phase_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [HOLD_W-1:0]       hold_cnt;
  logic                    accept, store_pend, phase_end, last_bit, hold_end;

  // Sign-extend both operands by one bit so the sum cannot wrap.
  assign sum = {wave_i[W], wave_i} + {offset_i[W], offset_i};

  always_comb begin
    clamp = sum[W-1:0];
    if (sum[W+1])  clamp = '0;   // negative
    else if (sum[W]) clamp = '1; // above 2^W-1
  end

  assign code = clamp[W-1 -: DAC_BITWIDTH];

  assign accept     = (state == S_IDLE) && enable_i && (sample_valid_i || pend_vld);
  // A strobe that meets an already-full slot in IDLE is also written into the
  // slot (the direct sample is still the one sent this frame).
  assign store_pend = enable_i && sample_valid_i && ((state != S_IDLE) || pend_vld);
  assign phase_end  = (phase_cnt == PH_W'(2 * SCLK_DIV - 1));
  assign last_bit   = (bit_cnt == BIT_W'(FRAME_BITS - 1));
  assign hold_end   = (hold_cnt == HOLD_W'(CS_HIGH_CYCLES - 1));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_SHIFT;
      S_SHIFT:  if (phase_end && last_bit) state_nxt = S_CSHOLD;
      S_CSHOLD: if (hold_end) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    spi_sclk_o = 1'b0;
    spi_mosi_o = 1'b0;
    spi_cs_o   = 1'b1;
    busy_o     = (state != S_IDLE);
    case (state)
      S_LOAD: begin
        spi_cs_o   = 1'b0;
        spi_mosi_o = shreg[FRAME_BITS-1];
      end
      S_SHIFT: begin
        spi_cs_o   = 1'b0;
        spi_mosi_o = shreg[FRAME_BITS-1];
        // First SCLK_DIV cycles of a bit are the low phase, rest high.
        spi_sclk_o = (phase_cnt >= PH_W'(SCLK_DIV));
      end
      default: ;
    endcase
  end

  // Datapath: pending slot, overrun flag, shift register, timing counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_vld  <= 1'b0;
      pend_code <= '0;
      overrun_o <= 1'b0;
      shreg     <= '0;
      phase_cnt <= '0;
      bit_cnt   <= '0;
      hold_cnt  <= '0;
    end else begin
      if (!enable_i) begin
        pend_vld <= 1'b0;
      end else if (store_pend) begin
        pend_vld  <= 1'b1;
        pend_code <= code;
      end else if (accept) begin
        pend_vld <= 1'b0; // pending slot consumed
      end

      if (clr_overrun_i)              overrun_o <= 1'b0;
      else if (store_pend && pend_vld) overrun_o <= 1'b1;

      if (accept)
        shreg <= {CMD, sample_valid_i ? code : pend_code};
      else if ((state == S_SHIFT) && phase_end)
        shreg <= {shreg[FRAME_BITS-2:0], 1'b0}; // MOSI moves at end of high phase

      if (state == S_SHIFT) phase_cnt <= phase_end ? '0 : phase_cnt + 1'b1;
      else                  phase_cnt <= '0;

      if (state != S_SHIFT)  bit_cnt <= '0;
      else if (phase_end)    bit_cnt <= bit_cnt + 1'b1;

      if (state == S_CSHOLD) hold_cnt <= hold_cnt + 1'b1;
      else                   hold_cnt <= '0;
    end
  end

endmodule
